spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
- Shares one spi_master instance among NUM_REQ independent requesters, using round-robin arbitration.
- Each accepted request is one full-duplex SPI word transfer to a selected slave.
- The block latches the request, launches the master, waits for completion or timeout, and returns the received word to the requester that owns the transfer.
- It sits between the system-side requesters and the SPI master control interface (start, tx data, busy, done, rx data).

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 16: SPI word width; must match the master.
- NUM_SLAVES, 4: number of slave devices addressable through the master.
- SLV_IDX_W, 2: width of a per-request slave index field.
- TIMEOUT_CYCLES, 4096: clk cycles allowed in WAIT_DONE before an error completion (≥2).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, NUM_REQ: per-requester request pending.
- req_ready, output, NUM_REQ: per-requester accept; combinational, one-hot or zero.
- req_data, input, NUM_REQ*DATA_WIDTH: per-requester tx word; requester i uses slice i.
- req_slave, input, NUM_REQ*SLV_IDX_W: per-requester target slave index.
- rsp_valid, output, NUM_REQ: one-cycle completion pulse to the owning requester.
- rsp_data, output, DATA_WIDTH: received word; valid while any rsp_valid bit is high.
- rsp_error, output, 1: completion was a reject or a timeout; valid with rsp_valid.
- grant_id, output, $clog2(NUM_REQ): index of the current/last owner.
- m_start, output, 1: start pulse to the master.
- m_tx_data, output, DATA_WIDTH: word to transmit.
- m_slave_sel, output, NUM_SLAVES: one-hot active-high target select.
- m_busy, input, 1: master busy.
- m_done, input, 1: master completion (irq) pulse.
- m_rx_data, input, DATA_WIDTH: master received word.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all outputs 0; timeout counter 0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset mid-transfer abandons the transfer silently: no rsp_valid.
- States: IDLE, LAUNCH, WAIT_DONE, RESPOND.
- IDLE:
  - Winner = first i with req_valid[i] set, scanning last_grant+1, +2, … modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle; the handshake completes on valid&&ready.
  - On the handshake, latch req_data slice, req_slave slice and winner into grant_id.
  - If slave index < NUM_SLAVES, go to LAUNCH. Otherwise go to RESPOND with error=1 and data=0; the master is never touched.
  - Requesters must hold valid and data until ready. req_valid deasserting before ready is legal and not an error.
- LAUNCH:
  - m_start = !m_busy (combinational). The state is held while m_busy=1.
  - Leave to WAIT_DONE in the cycle m_start=1, and clear the timeout counter.
- WAIT_DONE:
  - The counter increments each cycle.
  - m_done=1: capture m_rx_data, error=0, go to RESPOND.
  - Counter==TIMEOUT_CYCLES-1 with no m_done: data=0, error=1, go to RESPOND.
  - m_done on the timeout cycle counts as success.
- RESPOND:
  - rsp_valid[grant_id]=1 for exactly one cycle, with rsp_data and rsp_error registered.
  - last_grant<=grant_id; go to IDLE.
- Stable outputs:
  - m_tx_data and m_slave_sel (decoded latched index) are held constant from LAUNCH entry through the RESPOND cycle.
  - Both are 0 in IDLE.
- Only one transfer is ever outstanding.
- Minimum spacing between accepts = 3 cycles + master time. A new request cannot be accepted in the RESPOND cycle.
- Latency:
  - Accept to m_start is 1 cycle if the master is idle.
  - m_done to rsp_valid is 1 cycle.
- m_done or m_busy activity outside LAUNCH/WAIT_DONE is ignored.
- rsp_data and rsp_error are 0 when no rsp_valid bit is high.

Test Plan:
- Single request:
  - Stimulus: requester 2 with data 16'h1234, slave 1; model returns m_done with 16'hBEEF 20 cycles after start.
  - Response: req_ready[2] in the valid cycle; m_start next cycle with m_tx_data=16'h1234 and m_slave_sel=4'b0010; rsp_valid[2] one cycle after m_done with rsp_data=16'hBEEF and rsp_error=0.
- Round robin: all four req_valid held high for 5 transfers → grant order 0,1,2,3,0; each rsp_valid goes only to the owner.
- Invalid slave: NUM_SLAVES=3, requester 1 with slave index 3 → m_start never asserts; rsp_valid[1] with rsp_error=1 and rsp_data=0 one cycle after accept.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=64 and m_done never asserts.
  - Response: rsp_error=1 with rsp_valid exactly 64 cycles after m_start.
  - Variant: m_done on cycle 63 after m_start gives rsp_error=0.
- Busy hold: m_busy=1 for 10 cycles after accept → m_start stays 0 and then pulses the first cycle m_busy=0; m_tx_data is stable throughout.
- Reset mid-transfer:
  - Stimulus: assert rst_n low during WAIT_DONE with requester 3 active.
  - Response: all outputs 0 immediately and no rsp_valid; after release with requesters 0 and 3 valid, requester 0 is granted first.

Source files
------------

// File: rtl/spi_xfer_arbiter_if.sv
// Requester-side and SPI-master-side signals of the shared SPI transfer arbiter.
// The arbiter takes the slave modport; the requesters/master model take the master modport.
interface spi_xfer_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_IDX_W  = 2
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ*SLV_IDX_W-1:0]  req_slave;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_error;
    logic [GID_W-1:0]              grant_id;
    logic                          m_start;
    logic [DATA_WIDTH-1:0]         m_tx_data;
    logic [NUM_SLAVES-1:0]         m_slave_sel;
    logic                          m_busy;
    logic                          m_done;
    logic [DATA_WIDTH-1:0]         m_rx_data;

    modport slave (
        input  req_valid, req_data, req_slave, m_busy, m_done, m_rx_data,
        output req_ready, rsp_valid, rsp_data, rsp_error, grant_id,
               m_start, m_tx_data, m_slave_sel
    );

    modport master (
        output req_valid, req_data, req_slave, m_busy, m_done, m_rx_data,
        input  req_ready, rsp_valid, rsp_data, rsp_error, grant_id,
               m_start, m_tx_data, m_slave_sel
    );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin sharing of one SPI master among NUM_REQ requesters, one word transfer at a time.
// Accept->m_start 1 cycle (master idle), m_done->rsp 1 cycle; req_ready only in IDLE, m_start held off while m_busy.
module spi_xfer_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_SLAVES     = 4,
    parameter int SLV_IDX_W      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic              clk,
    input logic              rst_n,
    spi_xfer_arbiter_if.slave bus
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESPOND} state_t;

    state_t                state, state_nxt;
    logic [GID_W-1:0]      last_grant;
    logic [GID_W-1:0]      grant;
    logic [GID_W-1:0]      win_idx;
    logic                  win_vld;
    logic [DATA_WIDTH-1:0] win_dat;
    logic [SLV_IDX_W-1:0]  win_slv;
    logic                  slv_ok;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [SLV_IDX_W-1:0]  slv_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt;
    logic                  tmo;

    // Scan from last_grant+1 upward; descending loop lets the nearest requester win.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req_valid[GID_W'((int'(last_grant) + k) % NUM_REQ)]) begin
                win_vld = 1'b1;
                win_idx = GID_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    assign win_dat = bus.req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign win_slv = bus.req_slave[int'(win_idx)*SLV_IDX_W +: SLV_IDX_W];
    assign slv_ok  = int'(win_slv) < NUM_SLAVES;

    // Counter is cleared on leaving LAUNCH, so it reads (cycles since m_start - 1);
    // firing at TIMEOUT_CYCLES-2 puts the error response TIMEOUT_CYCLES after m_start.
    assign tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.m_start = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = slv_ok ? LAUNCH : RESPOND;
                end
            end
            LAUNCH: begin
                if (!bus.m_busy) begin
                    bus.m_start = 1'b1;
                    state_nxt   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.m_done || tmo) begin
                    state_nxt = RESPOND;
                end
            end
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GID_W'(NUM_REQ - 1);
            grant      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            slv_q      <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant <= win_idx;
                        tx_q  <= win_dat;
                        slv_q <= win_slv;
                        rx_q  <= '0;
                        err_q <= !slv_ok;
                    end
                end
                LAUNCH: cnt <= '0;
                WAIT_DONE: begin
                    cnt <= cnt + 1'b1;
                    if (bus.m_done) begin
                        rx_q  <= bus.m_rx_data;
                        err_q <= 1'b0;
                    end else if (tmo) begin
                        rx_q  <= '0;
                        err_q <= 1'b1;
                    end
                end
                RESPOND: last_grant <= grant;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.m_slave_sel = '0;
        if (state == IDLE && win_vld) begin
            bus.req_ready[win_idx] = 1'b1;
        end
        if (state == RESPOND) begin
            bus.rsp_valid[grant] = 1'b1;
        end
        // Out-of-range indices decode to no select at all.
        for (int i = 0; i < NUM_SLAVES; i++) begin
            bus.m_slave_sel[i] = (state != IDLE) && (int'(slv_q) == i);
        end
    end

    assign bus.rsp_data  = (state == RESPOND) ? rx_q : '0;
    assign bus.rsp_error = (state == RESPOND) ? err_q : 1'b0;
    assign bus.m_tx_data = (state != IDLE) ? tx_q : '0;
    assign bus.grant_id  = grant;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: 4 requesters, 3 slaves, 64-cycle timeout.
// Expected responses are queued when stimulus is driven and checked when rsp_valid appears.
module tb_spi_xfer_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int NS = 3;
    localparam int SW = 2;
    localparam int TO = 64;

    typedef struct {
        int          id;
        logic [15:0] dat;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   fails;
    int   cyc;
    exp_t q[$];

    spi_xfer_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLV_IDX_W(SW)) bus ();

    spi_xfer_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLV_IDX_W(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] oh(input int i);
        return 32'(1) << i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int id, input logic [15:0] dat, input logic [1:0] slv);
        bus.req_data[id*DW +: DW]  = dat;
        bus.req_slave[id*SW +: SW] = slv;
    endtask

    task automatic accept(input int id, input logic [15:0] dat, input logic [1:0] slv);
        set_req(id, dat, slv);
        bus.req_valid = 4'(oh(id));
        #1;
        chk("accept_rdy", 32'(bus.req_ready), oh(id));
        tick();
        bus.req_valid = '0;
        #1;
    endtask

    task automatic wait_rsp();
        int   n;
        exp_t e;
        n = 0;
        while (bus.rsp_valid == '0 && n < 300) begin
            tick();
            #1;
            n++;
        end
        if (q.size() > 0) e = q.pop_front();
        else e = '{id: -1, dat: 16'h0, err: 1'b0, cyc: -1};
        chk("rsp_vld", 32'(bus.rsp_valid), (e.id >= 0) ? oh(e.id) : 32'h0);
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.dat));
        chk("rsp_err", 32'(bus.rsp_error), 32'(e.err));
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        chk("rdy_in_rsp", 32'(bus.req_ready), 0);
        tick();
        #1;
        chk("rsp_pulse", 32'(bus.rsp_valid), 0);
        chk("rsp_data_idle", 32'(bus.rsp_data), 0);
    endtask

    // Entered in the m_start cycle; m_done comes dly cycles later.
    task automatic finish_xfer(input int id, input int dly, input logic [15:0] rx);
        repeat (dly) tick();
        bus.m_done    = 1'b1;
        bus.m_rx_data = rx;
        q.push_back('{id: id, dat: rx, err: 1'b0, cyc: cyc + 1});
        tick();
        bus.m_done    = 1'b0;
        bus.m_rx_data = 16'h0;
        #1;
        wait_rsp();
    endtask

    initial begin
        int bad;
        vectors = 0;
        fails   = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_slave = '0;
        bus.m_busy    = 1'b0;
        bus.m_done    = 1'b0;
        bus.m_rx_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_vld", 32'(bus.rsp_valid), 0);
        chk("rst_start", 32'(bus.m_start), 0);
        chk("rst_tx", 32'(bus.m_tx_data), 0);
        chk("rst_sel", 32'(bus.m_slave_sel), 0);
        chk("rst_gid", 32'(bus.grant_id), 0);
        rst_n = 1'b1;
        tick();

        // Round robin with every requester asserting
        for (int i = 0; i < NR; i++) set_req(i, 16'h1000 + 16'(i), 2'(i % 3));
        bus.req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            int n;
            int id;
            n  = 0;
            id = k % 4;
            while (bus.req_ready == '0 && n < 10) begin
                tick();
                #1;
                n++;
            end
            chk("rr_grant", 32'(bus.req_ready), oh(id));
            tick();
            #1;
            chk("rr_start", 32'(bus.m_start), 1);
            chk("rr_gid", 32'(bus.grant_id), 32'(id));
            chk("rr_tx", 32'(bus.m_tx_data), 32'h1000 + 32'(id));
            finish_xfer(id, 3, 16'hA000 + 16'(k));
        end
        bus.req_valid = '0;
        tick();

        // Single request
        accept(2, 16'h1234, 2'd1);
        chk("single_start", 32'(bus.m_start), 1);
        chk("single_tx", 32'(bus.m_tx_data), 32'h1234);
        chk("single_sel", 32'(bus.m_slave_sel), 32'h2);
        chk("single_gid", 32'(bus.grant_id), 2);
        finish_xfer(2, 20, 16'hBEEF);
        tick();

        // Invalid slave index: reject without touching the master
        q.push_back('{id: 1, dat: 16'h0, err: 1'b1, cyc: cyc + 1});
        accept(1, 16'hDEAD, 2'd3);
        chk("inv_no_start", 32'(bus.m_start), 0);
        chk("inv_sel", 32'(bus.m_slave_sel), 0);
        wait_rsp();
        tick();

        // Timeout with no m_done
        accept(0, 16'h0101, 2'd0);
        chk("tmo_start", 32'(bus.m_start), 1);
        q.push_back('{id: 0, dat: 16'h0, err: 1'b1, cyc: cyc + TO});
        wait_rsp();
        tick();

        // m_done on the last allowed cycle is a success
        accept(3, 16'h0303, 2'd1);
        chk("tmo63_start", 32'(bus.m_start), 1);
        finish_xfer(3, TO - 1, 16'h5A5A);
        tick();

        // Busy hold
        bus.m_busy = 1'b1;
        accept(2, 16'hC3C3, 2'd2);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.m_start !== 1'b0 || bus.m_tx_data !== 16'hC3C3) bad++;
            tick();
        end
        chk("busy_hold_bad_cycles", 32'(bad), 0);
        bus.m_busy = 1'b0;
        #1;
        chk("busy_release_start", 32'(bus.m_start), 1);
        chk("busy_tx", 32'(bus.m_tx_data), 32'hC3C3);
        chk("busy_sel", 32'(bus.m_slave_sel), 32'h4);
        finish_xfer(2, 5, 16'h6666);
        tick();

        // Reset in WAIT_DONE, then priority restarts at requester 0
        accept(3, 16'h7E7E, 2'd2);
        chk("mr_start", 32'(bus.m_start), 1);
        repeat (5) tick();
        chk("mr_wait_tx", 32'(bus.m_tx_data), 32'h7E7E);
        rst_n = 1'b0;
        #1;
        chk("mr_tx", 32'(bus.m_tx_data), 0);
        chk("mr_sel", 32'(bus.m_slave_sel), 0);
        chk("mr_gid", 32'(bus.grant_id), 0);
        chk("mr_rsp_vld", 32'(bus.rsp_valid), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid !== '0) bad++;
        end
        chk("mr_no_rsp", 32'(bad), 0);
        set_req(0, 16'h0A0A, 2'd0);
        set_req(3, 16'h3B3B, 2'd1);
        bus.req_valid = 4'b1001;
        #1;
        chk("mr_first_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b1000;
        #1;
        chk("mr_r0_start", 32'(bus.m_start), 1);
        finish_xfer(0, 2, 16'h0F0F);
        chk("mr_second_grant", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        #1;
        chk("mr_r3_start", 32'(bus.m_start), 1);
        chk("mr_r3_tx", 32'(bus.m_tx_data), 32'h3B3B);
        finish_xfer(3, 2, 16'hF0F0);
        chk("sb_drained", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
